// File: rtl/tcp_vlg_pkg.sv
// Shared types and limits for the TCP user-data tx gearbox: FIFO entry layout,
// parameter bounds and the keep-clamp helper.
package tcp_vlg_pkg;

   localparam int MIN_N_BYTES = 1;
   localparam int MAX_N_BYTES = 8;
   localparam int MIN_DEPTH   = 4;
   localparam int KEEP_W      = 4;  // holds 0..MAX_N_BYTES
   localparam int IDX_W       = 3;  // byte index 0..MAX_N_BYTES-1

   // Entries are sized for the widest word; unused upper bytes are tied to zero.
   typedef struct packed {
      logic [8*MAX_N_BYTES-1:0] dat;
      logic [KEEP_W-1:0]        keep;
      logic                     snd;
   } entry_t;

   function automatic logic [KEEP_W-1:0] clamp_keep(input logic [KEEP_W-1:0] keep,
                                                    input int n_bytes);
      logic [KEEP_W-1:0] lim;
      lim = KEEP_W'(n_bytes);
      return (keep > lim) ? lim : keep;
   endfunction

endpackage

// File: rtl/tcp_vlg_gearbox_fifo.sv
// Synchronous word FIFO for the tx gearbox: head is visible without a read
// (show-ahead), full/empty/cts come from registers fed by next-state occupancy.
module tcp_vlg_gearbox_fifo
   import tcp_vlg_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   wr_en,
   input  entry_t wr_data,
   input  logic   rd_en,
   output entry_t rd_data,
   output logic   full,
   output logic   empty,
   output logic   cts
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic            wr;
   logic            rd;

   assign wr      = wr_en && !full;
   assign rd      = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      // NOTE: default first so every path assigns count_nxt; otherwise a latch is inferred.
      count_nxt = count;
      if (wr && !rd)
         count_nxt = count + CW'(1);
      else if (rd && !wr)
         count_nxt = count - CW'(1);
   end

   // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (wr)
         mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         cts    <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
         // Two free slots leave room for a word already in flight when cts drops.
         cts   <= (count_nxt <= CW'(DEPTH - 2));
      end
   end

endmodule

// File: rtl/tcp_vlg_tx_gearbox.sv
// Word-to-byte tx gearbox feeding the TCP engine tx path (tcp_data dat/val/snd/cts).
// Optional macro TCP_VLG_GEARBOX_STAT_EN adds the 32-bit bytes_sent counter port.
module tcp_vlg_tx_gearbox
   import tcp_vlg_pkg::*;
#(
   parameter int N_BYTES = 4,
   parameter int DEPTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [8*N_BYTES-1:0]         in_dat,
   input  logic [$clog2(N_BYTES+1)-1:0] in_keep,
   input  logic                         in_val,
   input  logic                         in_snd,
   output logic                         in_cts,
   output logic [7:0]                   out_dat,
   output logic                         out_val,
   output logic                         out_snd,
   input  logic                         out_cts,
   output logic                         ovf,
`ifdef TCP_VLG_GEARBOX_STAT_EN
   output logic [31:0]                  bytes_sent,
`endif
   output logic                         empty
);

   if (N_BYTES < MIN_N_BYTES || N_BYTES > MAX_N_BYTES || DEPTH < MIN_DEPTH ||
       (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
      $error("tcp_vlg_tx_gearbox: illegal N_BYTES or DEPTH");
   end

   entry_t             wr_entry;
   entry_t             head;
   logic [KEEP_W-1:0]  keep_c;
   logic               fifo_wr;
   logic               fifo_rd;
   logic               fifo_full;
   logic               fifo_empty;

   entry_t             ser;
   logic [IDX_W-1:0]   ser_idx;
   logic               ser_valid;

   entry_t             cur;
   logic [IDX_W-1:0]   cur_idx;
   logic               cur_last;
   logic [7:0]         cur_byte;
   logic               xfer;

   assign keep_c  = clamp_keep(KEEP_W'(in_keep), N_BYTES);
   assign fifo_wr = in_val && (keep_c != '0);

   always_comb begin
      wr_entry                    = '0;
      wr_entry.dat[8*N_BYTES-1:0] = in_dat;
      wr_entry.keep               = keep_c;
      wr_entry.snd                = in_snd;
   end

   tcp_vlg_gearbox_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_data (wr_entry),
      .rd_en   (fifo_rd),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .cts     (in_cts)
   );

   // An idle serializer takes byte 0 straight from the FIFO head, which keeps
   // first-byte latency at two cycles and removes bubbles between words.
   always_comb begin
      cur      = ser_valid ? ser : head;
      cur_idx  = ser_valid ? ser_idx : '0;
      xfer     = out_cts && (ser_valid || !fifo_empty);
      fifo_rd  = xfer && !ser_valid;
      cur_last = ({1'b0, cur_idx} == (cur.keep - KEEP_W'(1)));
      cur_byte = cur.dat[{cur_idx, 3'b000} +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ser       <= '0;
         ser_idx   <= '0;
         ser_valid <= 1'b0;
         out_dat   <= '0;
         out_val   <= 1'b0;
         out_snd   <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         out_val <= xfer;
         out_dat <= xfer ? cur_byte : 8'h00;
         out_snd <= xfer && cur_last && cur.snd;
         ovf     <= fifo_wr && fifo_full;
         if (xfer) begin
            if (cur_last) begin
               ser_valid <= 1'b0;
            end else begin
               ser       <= cur;
               ser_idx   <= cur_idx + IDX_W'(1);
               ser_valid <= 1'b1;
            end
         end
      end
   end

   assign empty = fifo_empty && !ser_valid;

`ifdef TCP_VLG_GEARBOX_STAT_EN
   always_ff @(posedge clk) begin
      if (rst)
         bytes_sent <= '0;
      else
         bytes_sent <= bytes_sent + 32'(out_val);
   end
`endif

endmodule

// File: tb/tb_tcp_vlg_tx_gearbox.sv
// Scoreboard bench for tcp_vlg_tx_gearbox (N_BYTES=4, DEPTH=4): expected bytes are
// queued when words are driven and compared by a byte monitor on the falling edge.
module tb_tcp_vlg_tx_gearbox;

   localparam int N_BYTES = 4;
   localparam int DEPTH   = 4;

   typedef struct packed {
      logic [7:0] dat;
      logic       snd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_dat;
   logic [2:0]  in_keep;
   logic        in_val;
   logic        in_snd;
   logic        in_cts;
   logic [7:0]  out_dat;
   logic        out_val;
   logic        out_snd;
   logic        out_cts;
   logic        ovf;
   logic        empty;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];
   int   val_cyc[$];
   exp_t e;

   tcp_vlg_tx_gearbox #(
      .N_BYTES (N_BYTES),
      .DEPTH   (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_dat  (in_dat),
      .in_keep (in_keep),
      .in_val  (in_val),
      .in_snd  (in_snd),
      .in_cts  (in_cts),
      .out_dat (out_dat),
      .out_val (out_val),
      .out_snd (out_snd),
      .out_cts (out_cts),
      .ovf     (ovf),
      .empty   (empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Byte monitor: every out_val byte is checked against the scoreboard head.
   always @(negedge clk) begin
      if (mon_en) begin
         total++;
         if (out_val === 1'b1) begin
            val_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL byte_unexpected: got dat=%02h snd=%0b, required no byte", out_dat, out_snd);
            end else begin
               e = exp_q.pop_front();
               if ({out_dat, out_snd} !== {e.dat, e.snd}) begin
                  bad++;
                  $display("FAIL byte_data: got dat=%02h snd=%0b, required dat=%02h snd=%0b",
                           out_dat, out_snd, e.dat, e.snd);
               end
            end
         end else if (out_val !== 1'b0 || out_dat !== 8'h00 || out_snd !== 1'b0) begin
            bad++;
            $display("FAIL idle_outputs: got val=%b dat=%02h snd=%b, required 0/00/0", out_val, out_dat, out_snd);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one word for one edge; queues the first n_exp bytes as expected output.
   task automatic send(input logic [31:0] dat, input logic [2:0] keep, input logic snd,
                       input int n_exp, output int wcyc);
      int kc;
      in_dat  = dat;
      in_keep = keep;
      in_snd  = snd;
      in_val  = 1'b1;
      step();
      wcyc   = cyc;
      in_val = 1'b0;
      in_snd = 1'b0;
      kc = (keep > 3'd4) ? 4 : int'(keep);
      for (int i = 0; i < n_exp; i++)
         exp_q.push_back('{dat: dat[8*i +: 8], snd: snd && (i == kc - 1)});
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || out_val) && n < 200) begin
         step();
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: got %0d bytes still pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      total++;
      if ({out_val, out_dat, out_snd, ovf, in_cts, empty} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_state: got val=%b dat=%02h snd=%b ovf=%b in_cts=%b empty=%b, required 0 00 0 0 0 1",
                  out_val, out_dat, out_snd, ovf, in_cts, empty);
      end
      rst = 1'b0;
      total++;
      if (in_cts !== 1'b0) begin
         bad++;
         $display("FAIL reset_cts_early: got %b, required 0", in_cts);
      end
      step();
      total++;
      if (in_cts !== 1'b1) begin
         bad++;
         $display("FAIL reset_cts_release: got %b, required 1", in_cts);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_single();
      int w;
      val_cyc.delete();
      send(32'h44332211, 3'd4, 1'b0, 4, w);
      total++;
      if (empty !== 1'b0) begin
         bad++;
         $display("FAIL single_empty: got %b, required 0", empty);
      end
      drain("single");
      total++;
      if (val_cyc.size() != 4) begin
         bad++;
         $display("FAIL single_count: got %0d bytes, required 4", val_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (val_cyc[i] != w + 1 + i) begin
               bad++;
               $display("FAIL single_timing%0d: got cycle %0d, required %0d", i, val_cyc[i], w + 1 + i);
            end
         end
      end
      step();
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL single_empty_after: got %b, required 1", empty);
      end
   endtask

   task automatic test_back_to_back();
      int w1;
      int w2;
      val_cyc.delete();
      send(32'h0000BBAA, 3'd2, 1'b0, 2, w1);
      send(32'h00EEDDCC, 3'd3, 1'b0, 3, w2);
      drain("b2b");
      total++;
      if (val_cyc.size() != 5) begin
         bad++;
         $display("FAIL b2b_count: got %0d bytes, required 5", val_cyc.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (val_cyc[i] != w1 + 1 + i) begin
               bad++;
               $display("FAIL b2b_timing%0d: got cycle %0d, required %0d", i, val_cyc[i], w1 + 1 + i);
            end
         end
      end
   endtask

   task automatic test_cts_stall();
      int w;
      int req[4];
      val_cyc.delete();
      send(32'h87654321, 3'd4, 1'b0, 4, w);
      step();
      out_cts = 1'b0;
      repeat (3) step();
      out_cts = 1'b1;
      drain("stall");
      req = '{w + 1, w + 5, w + 6, w + 7};
      total++;
      if (val_cyc.size() != 4) begin
         bad++;
         $display("FAIL stall_count: got %0d bytes, required 4", val_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (val_cyc[i] != req[i]) begin
               bad++;
               $display("FAIL stall_timing%0d: got cycle %0d, required %0d", i, val_cyc[i], req[i]);
            end
         end
      end
   endtask

   task automatic test_snd();
      int w;
      val_cyc.delete();
      send(32'h00635241, 3'd3, 1'b1, 3, w);
      drain("snd");
      total++;
      if (val_cyc.size() != 3) begin
         bad++;
         $display("FAIL snd_count: got %0d bytes, required 3", val_cyc.size());
      end
   endtask

   task automatic test_keep_edge();
      int w;
      send(32'hFFFFFFFF, 3'd0, 1'b0, 0, w);
      total++;
      if (empty !== 1'b1 || in_cts !== 1'b1) begin
         bad++;
         $display("FAIL keep0_write: got empty=%b in_cts=%b, required 1 1", empty, in_cts);
      end
      step();
      total++;
      if (ovf !== 1'b0) begin
         bad++;
         $display("FAIL keep0_ovf: got %b, required 0", ovf);
      end
      send(32'h88776655, 3'd7, 1'b1, 4, w);
      drain("keep_clamp");
   endtask

   task automatic test_overflow();
      int w;
      logic [31:0] d;
      out_cts = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = 32'h03020100 + 32'(i) * 32'h10101010;
         send(d, 3'd4, 1'b0, (i < 4) ? 4 : 0, w);
         total++;
         if (in_cts !== ((i < 2) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL ovf_in_cts%0d: got %b, required %b", i, in_cts, (i < 2) ? 1'b1 : 1'b0);
         end
         total++;
         if (ovf !== ((i == 4) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL ovf_pulse%0d: got %b, required %b", i, ovf, (i == 4) ? 1'b1 : 1'b0);
         end
      end
      step();
      total++;
      if (ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_single: got %b, required 0", ovf);
      end
      out_cts = 1'b1;
      drain("ovf");
      step();
      total++;
      if (in_cts !== 1'b1 || empty !== 1'b1) begin
         bad++;
         $display("FAIL ovf_recover: got in_cts=%b empty=%b, required 1 1", in_cts, empty);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      send(32'hDDCCBBAA, 3'd4, 1'b0, 2, w);
      step();
      step();
      rst = 1'b1;
      step();
      total++;
      if (out_val !== 1'b0 || empty !== 1'b1 || in_cts !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_state: got val=%b empty=%b in_cts=%b, required 0 1 0", out_val, empty, in_cts);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rstmid_bytes: got %0d of 2 pre-reset bytes missing, required 0", exp_q.size());
         exp_q.delete();
      end
      rst = 1'b0;
      repeat (10) step();
      total++;
      if (empty !== 1'b1 || in_cts !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_after: got empty=%b in_cts=%b, required 1 1", empty, in_cts);
      end
   endtask

   initial begin
      rst     = 1'b1;
      in_dat  = '0;
      in_keep = '0;
      in_val  = 1'b0;
      in_snd  = 1'b0;
      out_cts = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_cts_stall();
      test_snd();
      test_keep_edge();
      test_overflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tcp_vlg_tx_gearbox.md
TCP_VLG_TX_GEARBOX -- requirements
Module: tcp_vlg_tx_gearbox

Interface
REQ-001 SHALL have parameter N_BYTES, default 4, user word width in bytes (1..8).
REQ-002 SHALL have parameter DEPTH, default 16, FIFO depth in words (power of 2, >=4).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_dat  input  8*N_BYTES  user word; byte 0 = in_dat[7:0], sent first.
REQ-006 SHALL have port in_keep  input  $clog2(N_BYTES+1)  count of valid bytes in word, starting at byte 0.
REQ-007 SHALL have port in_val  input  1  word valid.
REQ-008 SHALL have port in_snd  input  1  force-send marker, qualified by in_val.
REQ-009 SHALL have port in_cts  output  1  user clear-to-send.
REQ-010 SHALL have port out_dat  output  8  byte to TCP engine tx path (tcp_data dat).
REQ-011 SHALL have port out_val  output  1  byte valid (tcp_data val).
REQ-012 SHALL have port out_snd  output  1  force-send pulse (tcp_data snd).
REQ-013 SHALL have port out_cts  input  1  engine clear-to-send (tcp_data cts).
REQ-014 SHALL have port ovf  output  1  one-cycle pulse: word dropped on full FIFO.
REQ-015 SHALL have port empty  output  1  FIFO and serializer both empty.

Function
REQ-016 SHALL write {in_dat, in_keep, in_snd} to FIFO when in_val=1, in_keep!=0 and FIFO not full.
REQ-017 SHALL ignore words with in_keep=0 (no write, no ovf), and clamp in_keep>N_BYTES to N_BYTES.
REQ-018 SHALL drop the word and pulse ovf next cycle when in_val=1, in_keep!=0 and FIFO full.
REQ-019 SHALL drive in_cts (registered) high only when free entries >=2, giving the user one-tick tolerance.
REQ-020 SHALL hold a serializer register (word, keep, snd, byte index) loaded from FIFO head.
REQ-021 SHALL register out_val: out_val(t)=1 iff out_cts(t-1)=1 and a byte was pending at t-1; each cycle with out_val=1 transfers one byte.
REQ-022 SHALL advance byte index per transferred byte; on last byte (index=keep-1) load next FIFO word same cycle, giving zero bubbles between words.
REQ-023 SHALL pulse out_snd coincident with the last out_val byte of a word written with in_snd=1.
REQ-024 SHALL achieve latency 2 cycles from write into empty block (out_cts high) to first out_val.
REQ-025 SHALL permit simultaneous FIFO write and read; full/empty derived from (DEPTH+1)-state occupancy counter; pointers wrap modulo DEPTH.
REQ-026 SHALL stop issuing bytes within one cycle of out_cts falling; out_dat/out_val hold 0 when out_val=0.

Reset
REQ-027 SHALL on rst clear FIFO pointers, occupancy, serializer; out_dat=0, out_val=0, out_snd=0, ovf=0, in_cts=0, empty=1.
REQ-028 SHALL assert in_cts one cycle after rst deasserts; rst mid-word discards all buffered bytes.

Configuration
REQ-029 SHALL, with TCP_VLG_GEARBOX_STAT_EN defined, add output bytes_sent (32 bit, wrapping, cleared on rst) counting transferred bytes; without it the port and counter SHALL not exist.

Structure
REQ-030 SHALL place the FIFO entry typedef and N_BYTES/DEPTH limit constants in tcp_vlg_pkg.
REQ-031 SHALL instantiate the storage as sub-module tcp_vlg_gearbox_fifo (synchronous FIFO, registered full/empty).

Verification
REQ-032 SHALL cover: N_BYTES=4, word 0x44332211 keep=4, out_cts=1 -> bytes 11,22,33,44 on cycles t+2..t+5.
REQ-033 SHALL cover: keep=2 then keep=3 back-to-back -> 5 contiguous out_val bytes, no bubble.
REQ-034 SHALL cover: out_cts low for 3 cycles mid-word -> out_val low exactly 3 cycles (shifted by 1), no byte lost/duplicated.
REQ-035 SHALL cover: DEPTH=4, out_cts=0, write 5 words -> in_cts low after 3rd, 5th word dropped, ovf pulses once.
REQ-036 SHALL cover: in_snd=1 on keep=3 word -> out_snd high only with 3rd byte.
REQ-037 SHALL cover: rst during byte 2 of 4 -> out_val=0 next cycle, empty=1, no residual bytes after release.
